// File: rtl/tjrpu_wb_pkg.sv
// Shared types and default sizing for the tjrpu Wishbone single-transfer initiator.
package tjrpu_wb_pkg;

  localparam int unsigned WBM_ADR_W          = 32;
  localparam int unsigned WBM_DAT_W          = 32;
  localparam int unsigned WBM_TIMEOUT_CYCLES = 255;
  localparam int unsigned WBM_CNT_W          = 16;

  typedef enum logic [1:0] {
    WBM_IDLE = 2'd0,
    WBM_BUS  = 2'd1,
    WBM_RESP = 2'd2
  } wbm_state_e;

endpackage

// File: rtl/wbm_timeout_ctr.sv
// Loadable saturating cycle counter; tc_o flags that the next counted cycle is the LIMIT-th.
module wbm_timeout_ctr
  import tjrpu_wb_pkg::*;
#(
  parameter int unsigned CNT_W = WBM_CNT_W,
  parameter int unsigned LIMIT = WBM_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tc_d = (cnt_d == CNT_W'(LIMIT - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/la_wb_master.sv
// Wishbone classic single-transfer initiator with valid/ready command and response channels.
// Optional ack timeout is enabled by defining TJRPU_WBM_TIMEOUT_EN.
module la_wb_master
  import tjrpu_wb_pkg::*;
#(
  parameter  int unsigned ADR_W          = WBM_ADR_W,
  parameter  int unsigned DAT_W          = WBM_DAT_W,
  localparam int unsigned SEL_W          = DAT_W / 8,
  parameter  int unsigned TIMEOUT_CYCLES = WBM_TIMEOUT_CYCLES
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [DAT_W-1:0] cmd_dat,
  input  logic [SEL_W-1:0] cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DAT_W-1:0] rsp_dat,
  output logic             rsp_err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [ADR_W-1:0] wbm_adr_o,
  output logic [DAT_W-1:0] wbm_dat_o,
  output logic [SEL_W-1:0] wbm_sel_o,
  input  logic             wbm_ack_i,
  input  logic [DAT_W-1:0] wbm_dat_i
);

  if ((DAT_W % 8) != 0 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("la_wb_master: DAT_W must be a multiple of 8 and TIMEOUT_CYCLES within 1..65535");
  end

  wbm_state_e       state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] dat_q, dat_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic             accept_c;

  assign accept_c = (state_q == WBM_IDLE) && cmd_valid && cmd_ready_q;

`ifdef TJRPU_WBM_TIMEOUT_EN
  logic rsp_err_q, rsp_err_d;
  logic tmo_tc;

  wbm_timeout_ctr #(
    .CNT_W (WBM_CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .load_i (accept_c),
    .inc_i  ((state_q == WBM_BUS) && !wbm_ack_i),
    .tc_o   (tmo_tc)
  );

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
`ifdef TJRPU_WBM_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      WBM_IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept_c) begin
          we_d        = cmd_we;
          adr_d       = cmd_adr;
          dat_d       = cmd_dat;
          sel_d       = cmd_sel;
          cyc_d       = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = WBM_BUS;
        end
      end
      WBM_BUS: begin
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_valid_d = 1'b1;
`ifdef TJRPU_WBM_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = WBM_RESP;
        end
`ifdef TJRPU_WBM_TIMEOUT_EN
        else if (tmo_tc) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = WBM_RESP;
        end
`endif
      end
      WBM_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = WBM_IDLE;
        end
      end
      default: begin
        state_d     = WBM_IDLE;
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= WBM_IDLE;
      cmd_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
`ifdef TJRPU_WBM_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
`ifdef TJRPU_WBM_TIMEOUT_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;

endmodule
